emaclite_tx_slave: RTL and testbench

- AXI4-Lite slave modelling the transmit side of the Ethernet MAC that the ARP request master writes into.
- Holds a word-addressed TX buffer, a length register and a control/busy register in a 13-bit address space.
- A start write to control streams the buffered frame out byte by byte on a valid/ready byte interface.
- Sits directly downstream of the ARP request generator. It terminates that generator's AW/W/B and AR/R channels and feeds the PHY-side byte sink.

---
 rtl/emaclite_tx_slave.sv | 224 ++++++++++++++++++++++
 tb/tb_emaclite_tx_slave.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emaclite_tx_slave.sv
// AXI4-Lite slave for the EMAC transmit side: word buffer, length and control registers,
// and a byte-stream transmitter that plays the buffered frame out on txd/txvalid/txready.
//
// state | meaning
// IDLE  | waiting; when busy is raised, latch effective length and rewind byte index
// SEND  | presenting buffer byte idx on txd until the final byte is accepted
// DONE  | frame finished (or empty); clears busy and returns to IDLE
module emaclite_tx_slave #(
    parameter int          BUF_WORDS = 508,
    parameter logic [12:0] LEN_ADDR  = 13'h07F4,
    parameter logic [12:0] CTRL_ADDR = 13'h07FC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [12:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [12:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic [7:0]  txd,
    output logic        txvalid,
    input  logic        txready,
    output logic        txlast
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [10:0] MAX_BYTES   = 11'(4 * BUF_WORDS);

    typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_t;

    tx_state_t   state_q, state_d;
    logic        rst_done_q;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [10:0] aw_word_q, aw_word_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] length_q, length_d;
    logic        busy_q, busy_d;
    logic [10:0] idx_q, idx_d, n_q, n_d;
    logic [31:0] buf_q [BUF_WORDS];

    logic        commit, w_in_buf, w_is_len, w_is_ctrl, w_high, mem_we;
    logic [10:0] ar_word;
    logic        r_in_buf, r_is_len, r_is_ctrl, r_high;
    logic [10:0] eff_len;
    logic [31:0] tx_word;
    logic        tx_last_w;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

    assign commit    = aw_held_q && w_held_q;
    assign w_in_buf  = aw_word_q < 11'(BUF_WORDS);
    assign w_is_len  = aw_word_q == LEN_ADDR[12:2];
    assign w_is_ctrl = aw_word_q == CTRL_ADDR[12:2];
    assign w_high    = aw_word_q[10:9] != 2'b00;
    assign mem_we    = commit && w_in_buf && !busy_q;

    assign ar_word   = araddr[12:2];
    assign r_in_buf  = ar_word < 11'(BUF_WORDS);
    assign r_is_len  = ar_word == LEN_ADDR[12:2];
    assign r_is_ctrl = ar_word == CTRL_ADDR[12:2];
    assign r_high    = ar_word[10:9] != 2'b00;

    assign eff_len   = (length_q > 16'(MAX_BYTES)) ? MAX_BYTES : length_q[10:0];
    assign tx_word   = buf_q[idx_q[10:2]];
    assign tx_last_w = (state_q == SEND) && (idx_q == n_q - 11'd1);

    assign awready = rst_done_q && !aw_held_q && !bvalid_q;
    assign wready  = rst_done_q && !w_held_q && !bvalid_q;
    assign arready = rst_done_q && !rvalid_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
    assign txvalid = state_q == SEND;
    assign txlast  = tx_last_w;
    assign txd     = (state_q == SEND) ? tx_word[{idx_q[1:0], 3'b000} +: 8] : 8'h00;

    always_comb begin
        aw_held_d = aw_held_q;
        aw_word_d = aw_word_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        length_d  = length_q;
        busy_d    = busy_q;
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;

        if (awvalid && awready) begin
            aw_held_d = 1'b1;
            aw_word_d = awaddr[12:2];
        end
        if (wvalid && wready) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_OKAY;
            if (w_high || ((w_in_buf || w_is_len) && busy_q))
                bresp_d = RESP_SLVERR;
            if (w_is_len && !busy_q) begin
                if (wstrb_q[0]) length_d[7:0]  = wdata_q[7:0];
                if (wstrb_q[1]) length_d[15:8] = wdata_q[15:8];
            end
            if (w_is_ctrl && wstrb_q[0] && wdata_q[0] && !busy_q)
                busy_d = 1'b1;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end

        // Data is captured at the AR handshake, so a same-cycle write is not yet visible.
        if (arvalid && arready) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = 32'h0;
            if (r_high)         rresp_d = RESP_SLVERR;
            else if (r_in_buf)  rdata_d = buf_q[araddr[10:2]];
            else if (r_is_len)  rdata_d = {16'h0, length_q};
            else if (r_is_ctrl) rdata_d = {31'h0, busy_q};
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    idx_d   = 11'd0;
                    n_d     = eff_len;
                    state_d = (eff_len == 11'd0) ? DONE : SEND;
                end
            end
            SEND: begin
                // Index stops on the last byte so the buffer read never leaves the array.
                if (txready) begin
                    if (tx_last_w) state_d = DONE;
                    else           idx_d   = idx_q + 11'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rst_done_q <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_word_q  <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            length_q   <= '0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
            idx_q      <= '0;
            n_q        <= '0;
        end else begin
            rst_done_q <= 1'b1;
            aw_held_q  <= aw_held_d;
            aw_word_q  <= aw_word_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            length_q   <= length_d;
            busy_q     <= busy_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
        end
    end

    // Frame buffer keeps its contents across reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) buf_q[aw_word_q[8:0]][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_emaclite_tx_slave.sv
// Directed bench for emaclite_tx_slave: register/buffer access over AXI4-Lite and
// the transmitted byte stream, with hand-computed expectations.
module tb_emaclite_tx_slave;

    localparam logic [12:0] LEN  = 13'h07F4;
    localparam logic [12:0] CTRL = 13'h07FC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [12:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [7:0]  txd;
    logic        txvalid;
    logic        txready = 1'b0;
    logic        txlast;

    int n_cmp = 0;
    int n_err = 0;
    int txv_cycles = 0;
    logic [7:0] rx_byte [2048];
    logic       rx_last [2048];
    int         rx_got;

    always #5 clk = ~clk;

    always @(negedge clk) if (txvalid === 1'b1) txv_cycles++;

    emaclite_tx_slave dut (
        .CLK(clk), .RST(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .txd(txd), .txvalid(txvalid), .txready(txready), .txlast(txlast)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int cyc;
        bit aw_ok, w_ok, hs_aw, hs_w;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        aw_ok = 0; w_ok = 0; cyc = 0;
        while (!(aw_ok && w_ok) && cyc < 20) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick(); cyc++;
            if (hs_aw) begin awvalid = 1'b0; aw_ok = 1; end
            if (hs_w)  begin wvalid = 1'b0;  w_ok = 1;  end
        end
        while (bvalid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        if (bvalid !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL write_timeout addr=%h bvalid=%b", a, bvalid);
            awvalid = 1'b0; wvalid = 1'b0; resp = 2'bxx;
        end else begin
            resp = bresp; bready = 1'b1;
            tick();
            bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [12:0] a, output logic [31:0] d, output logic [1:0] resp);
        int cyc;
        araddr = a; arvalid = 1'b1; cyc = 0;
        while (arready !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        tick();
        arvalid = 1'b0;
        while (rvalid !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        if (rvalid !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL read_timeout addr=%h rvalid=%b", a, rvalid);
            d = 'x; resp = 2'bxx;
        end else begin
            d = rdata; resp = rresp; rready = 1'b1;
            tick();
            rready = 1'b0;
        end
    endtask

    task automatic collect(input int n, input int limit);
        int cyc;
        rx_got = 0; cyc = 0;
        while (rx_got < n && cyc < limit) begin
            txready = 1'b1;
            if (txvalid === 1'b1) begin
                rx_byte[rx_got] = txd;
                rx_last[rx_got] = txlast;
                rx_got++;
            end
            tick(); cyc++;
        end
        txready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic [1:0] rr;
        tick(); tick();
        n_cmp++; if (awready !== 1'b0) begin n_err++; $display("FAIL rst_awready got=%b want=0", awready); end
        n_cmp++; if (wready !== 1'b0) begin n_err++; $display("FAIL rst_wready got=%b want=0", wready); end
        n_cmp++; if (arready !== 1'b0) begin n_err++; $display("FAIL rst_arready got=%b want=0", arready); end
        n_cmp++; if ({bvalid, rvalid, txvalid, txlast} !== 4'b0000) begin n_err++;
            $display("FAIL rst_valids got=%b want=0000", {bvalid, rvalid, txvalid, txlast}); end
        n_cmp++; if ({bresp, rresp, rdata, txd} !== '0) begin n_err++;
            $display("FAIL rst_data got=%h/%h/%h/%h want=0", bresp, rresp, rdata, txd); end
        #2 rst = 1'b0;
        tick();
        n_cmp++; if ({awready, wready, arready} !== 3'b111) begin n_err++;
            $display("FAIL rst_release_ready got=%b want=111", {awready, wready, arready}); end
        axi_read(LEN, rd, rr);
        n_cmp++; if (rd !== 32'h0 || rr !== 2'b00) begin n_err++; $display("FAIL rst_len got=%h/%b want=0/00", rd, rr); end
        axi_read(CTRL, rd, rr);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_busy got=%h want=0", rd); end
    endtask

    task automatic test_basic_frame();
        logic [31:0] rd; logic [1:0] rr, wr;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        axi_write(13'h0000, 32'h44332211, 4'hF, wr);
        n_cmp++; if (wr !== 2'b00) begin n_err++; $display("FAIL basic_buf_bresp got=%b want=00", wr); end
        axi_write(LEN, 32'd3, 4'h3, wr);
        n_cmp++; if (wr !== 2'b00) begin n_err++; $display("FAIL basic_len_bresp got=%b want=00", wr); end
        axi_write(CTRL, 32'd1, 4'h1, wr);
        n_cmp++; if (wr !== 2'b00) begin n_err++; $display("FAIL basic_ctrl_bresp got=%b want=00", wr); end
        axi_read(CTRL, rd, rr);
        n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL basic_busy_during got=%h want=1", rd); end
        collect(3, 50);
        n_cmp++; if (rx_got !== 3) begin n_err++; $display("FAIL basic_count got=%0d want=3", rx_got); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rx_byte[i] !== exp_b[i] || rx_last[i] !== (i == 2)) begin n_err++;
                $display("FAIL basic_byte%0d got=%h/%b want=%h/%b", i, rx_byte[i], rx_last[i], exp_b[i], i == 2); end
        end
        repeat (3) tick();
        n_cmp++; if (txvalid !== 1'b0) begin n_err++; $display("FAIL basic_txvalid_after got=%b want=0", txvalid); end
        axi_read(CTRL, rd, rr);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL basic_busy_after got=%h want=0", rd); end
    endtask

    task automatic test_aw_w_skew();
        logic [31:0] rd; logic [1:0] rr, wr;
        int bcount;
        bit hs_aw, hs_w;
        for (int order = 0; order < 2; order++) begin
            bcount = 0; bready = 1'b1;
            awaddr = (order == 0) ? 13'h0004 : 13'h0008;
            wdata  = (order == 0) ? 32'hA5A55A5A : 32'h0BADF00D;
            wstrb  = 4'hF;
            if (order == 0) awvalid = 1'b1; else wvalid = 1'b1;
            for (int c = 0; c < 12; c++) begin
                if (c == 3) begin if (order == 0) wvalid = 1'b1; else awvalid = 1'b1; end
                if (c == 2) begin
                    n_cmp++;
                    if ((order == 0 ? awready : wready) !== 1'b0) begin n_err++;
                        $display("FAIL skew%0d_held_ready got=%b want=0", order, order == 0 ? awready : wready); end
                end
                hs_aw = awvalid && awready;
                hs_w  = wvalid && wready;
                if (bvalid === 1'b1) bcount++;
                tick();
                if (hs_aw) awvalid = 1'b0;
                if (hs_w)  wvalid = 1'b0;
            end
            bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
            n_cmp++; if (bcount !== 1) begin n_err++; $display("FAIL skew%0d_bpulses got=%0d want=1", order, bcount); end
        end
        axi_read(13'h0004, rd, rr);
        n_cmp++; if (rd !== 32'hA5A55A5A) begin n_err++; $display("FAIL skew_aw_first_data got=%h want=a5a55a5a", rd); end
        axi_read(13'h0008, rd, rr);
        n_cmp++; if (rd !== 32'h0BADF00D) begin n_err++; $display("FAIL skew_w_first_data got=%h want=0badf00d", rd); end
        axi_write(13'h0008, 32'hFFFFFFFF, 4'b0101, wr);
        axi_read(13'h0008, rd, rr);
        n_cmp++; if (rd !== 32'h0BFFF0FF) begin n_err++; $display("FAIL partial_strobe got=%h want=0bfff0ff", rd); end
    endtask

    task automatic test_busy_reject();
        logic [31:0] rd; logic [1:0] rr, wr;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        axi_write(LEN, 32'd4, 4'h3, wr);
        axi_write(CTRL, 32'd1, 4'h1, wr);
        axi_write(13'h0000, 32'hFFFFFFFF, 4'hF, wr);
        n_cmp++; if (wr !== 2'b10) begin n_err++; $display("FAIL busy_buf_bresp got=%b want=10", wr); end
        axi_write(LEN, 32'h10, 4'h3, wr);
        n_cmp++; if (wr !== 2'b10) begin n_err++; $display("FAIL busy_len_bresp got=%b want=10", wr); end
        axi_write(13'h0900, 32'h1, 4'hF, wr);
        n_cmp++; if (wr !== 2'b10) begin n_err++; $display("FAIL high_write_bresp got=%b want=10", wr); end
        axi_write(13'h07F0, 32'h1234, 4'hF, wr);
        n_cmp++; if (wr !== 2'b00) begin n_err++; $display("FAIL hole_write_bresp got=%b want=00", wr); end
        axi_read(13'h0900, rd, rr);
        n_cmp++; if (rd !== 32'h0 || rr !== 2'b10) begin n_err++; $display("FAIL high_read got=%h/%b want=0/10", rd, rr); end
        axi_read(13'h07F0, rd, rr);
        n_cmp++; if (rd !== 32'h0 || rr !== 2'b00) begin n_err++; $display("FAIL hole_read got=%h/%b want=0/00", rd, rr); end
        axi_read(LEN, rd, rr);
        n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL busy_len_kept got=%h want=4", rd); end
        axi_read(13'h0000, rd, rr);
        n_cmp++; if (rd !== 32'h44332211) begin n_err++; $display("FAIL busy_buf_kept got=%h want=44332211", rd); end
        collect(4, 50);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rx_byte[i] !== exp_b[i] || rx_last[i] !== (i == 3)) begin n_err++;
                $display("FAIL busy_byte%0d got=%h/%b want=%h/%b", i, rx_byte[i], rx_last[i], exp_b[i], i == 3); end
        end
        repeat (3) tick();
    endtask

    task automatic test_stall();
        logic [1:0] wr;
        logic [7:0] exp_b [8];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        exp_b[4] = 8'h5A; exp_b[5] = 8'h5A; exp_b[6] = 8'hA5; exp_b[7] = 8'hA5;
        axi_write(LEN, 32'd8, 4'h3, wr);
        axi_write(CTRL, 32'd1, 4'h1, wr);
        collect(2, 50);
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if ({txvalid, txlast, txd} !== {1'b1, 1'b0, 8'h33}) begin n_err++;
                $display("FAIL stall_cycle%0d got=%b/%b/%h want=1/0/33", c, txvalid, txlast, txd); end
            tick();
        end
        collect(6, 50);
        n_cmp++; if (rx_got !== 6) begin n_err++; $display("FAIL stall_count got=%0d want=6", rx_got); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (rx_byte[i] !== exp_b[i+2] || rx_last[i] !== (i == 5)) begin n_err++;
                $display("FAIL stall_byte%0d got=%h/%b want=%h/%b", i + 2, rx_byte[i], rx_last[i], exp_b[i+2], i == 5); end
        end
        repeat (3) tick();
    endtask

    task automatic test_zero_length();
        logic [31:0] rd; logic [1:0] rr, wr;
        int snap;
        axi_write(LEN, 32'd0, 4'h3, wr);
        snap = txv_cycles;
        axi_write(CTRL, 32'd1, 4'h1, wr);
        n_cmp++; if (wr !== 2'b00) begin n_err++; $display("FAIL zero_ctrl_bresp got=%b want=00", wr); end
        tick();
        axi_read(CTRL, rd, rr);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL zero_busy got=%h want=0", rd); end
        n_cmp++; if (txv_cycles !== snap) begin n_err++; $display("FAIL zero_txvalid got=%0d want=0", txv_cycles - snap); end
    endtask

    task automatic test_max_length();
        logic [31:0] rd; logic [1:0] rr, wr;
        int lasts;
        axi_write(LEN, 32'h0000FFFF, 4'h3, wr);
        axi_read(LEN, rd, rr);
        n_cmp++; if (rd !== 32'h0000FFFF) begin n_err++; $display("FAIL max_len_reg got=%h want=0000ffff", rd); end
        axi_write(CTRL, 32'd1, 4'h1, wr);
        collect(2100, 2200);
        n_cmp++; if (rx_got !== 2032) begin n_err++; $display("FAIL max_count got=%0d want=2032", rx_got); end
        lasts = 0;
        for (int i = 0; i < rx_got; i++) if (rx_last[i] === 1'b1) lasts++;
        n_cmp++; if (lasts !== 1 || rx_last[2031] !== 1'b1) begin n_err++;
            $display("FAIL max_txlast got=%0d/%b want=1/1", lasts, rx_last[2031]); end
        n_cmp++; if ({rx_byte[0], rx_byte[4], rx_byte[8]} !== 24'h115AFF) begin n_err++;
            $display("FAIL max_bytes got=%h%h%h want=115aff", rx_byte[0], rx_byte[4], rx_byte[8]); end
        repeat (3) tick();
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd; logic [1:0] rr, wr;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        axi_write(LEN, 32'd64, 4'h3, wr);
        axi_write(CTRL, 32'd1, 4'h1, wr);
        collect(5, 50);
        n_cmp++; if ({txvalid, txd} !== {1'b1, 8'h5A}) begin n_err++;
            $display("FAIL midframe_byte5 got=%b/%h want=1/5a", txvalid, txd); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({txvalid, txlast, awready, arready} !== 4'b0000) begin n_err++;
            $display("FAIL midframe_async got=%b want=0000", {txvalid, txlast, awready, arready}); end
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        axi_read(CTRL, rd, rr);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL midframe_busy got=%h want=0", rd); end
        axi_write(LEN, 32'd4, 4'h3, wr);
        axi_write(CTRL, 32'd1, 4'h1, wr);
        collect(4, 50);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rx_byte[i] !== exp_b[i] || rx_last[i] !== (i == 3)) begin n_err++;
                $display("FAIL restart_byte%0d got=%h/%b want=%h/%b", i, rx_byte[i], rx_last[i], exp_b[i], i == 3); end
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_aw_w_skew();
        test_busy_reject();
        test_stall();
        test_zero_length();
        test_max_length();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
